// File: rtl/rv_writeback_pkg.sv
// Shared definitions for the writeback stage.
//   BIN_DIG       : default datapath width
//   load_funct3_e : load format codes carried on mem_funct3
//   grant_e       : arbiter winner encoding for the last_grant flop
package defs;

  localparam int unsigned BIN_DIG = 32;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_e;

  typedef enum logic {
    GrantExec = 1'b0,
    GrantMem  = 1'b1
  } grant_e;

endpackage

// File: rtl/rv_regfile.sv
// Architectural register file: NREG x XLEN, one write port, two async read ports.
// x0 is hardwired to zero: writes to it are discarded and reads return 0.
//   clk_i, rst_i          : clock, asynchronous active-high reset (clears all registers)
//   we_i, waddr_i, wdata_i: write port, takes effect at the rising edge
//   raddr1_i/rdata1_o     : read port 1
//   raddr2_i/rdata2_o     : read port 2
module rv_regfile #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr1_i,
  output logic [XLEN-1:0] rdata1_o,
  input  logic [4:0]      raddr2_i,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] regs_q [NREG];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = '0;
    rdata2_o = '0;
    if (raddr1_i != 5'd0) rdata1_o = regs_q[raddr1_i];
    if (raddr2_i != 5'd0) rdata2_o = regs_q[raddr2_i];
  end

endmodule

// File: rtl/rv_writeback.sv
// Writeback stage: arbitrates an exec-result channel and a load-result channel onto a single
// register write port, formats load data, tracks write-pending registers and counts retirements.
//   CLK, RST                         : clock, asynchronous active-high reset
//   ex_valid/ex_ready, ex_rd, ex_data: exec-result handshake
//   mem_valid/mem_ready, mem_rd, mem_data, mem_funct3, mem_byte_off: load-result handshake
//   issue_valid, issue_rd            : decode marks rd as write-pending
//   rs1/rs2 addr/data/pending        : read ports with pending flags
//   instret                          : 64-bit count of retired writebacks (wraps)
// Optional feature: define WB_BYPASS_EN to forward the transferring write to the read ports
// in the same cycle.
module rv_writeback
  import defs::*;
#(
  parameter int unsigned XLEN = BIN_DIG,
  parameter int unsigned NREG = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic [2:0]      mem_funct3,
  input  logic [1:0]      mem_byte_off,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_pending,
  output logic            rs2_pending,
  output logic [63:0]     instret
);

  grant_e          last_grant_q, last_grant_d;
  logic [NREG-1:0] pending_q, pending_d;
  logic [63:0]     instret_q, instret_d;

  logic            conflict;
  logic            ex_fire, mem_fire, wr_en;
  logic [4:0]      wr_rd;
  logic [XLEN-1:0] wr_data, ld_data;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] rf_rdata1, rf_rdata2;

  // On a conflict the channel that lost last time wins; a lone valid channel always wins.
  assign conflict  = ex_valid && mem_valid;
  assign ex_ready  = !RST && ex_valid && !(mem_valid && (last_grant_q == GrantExec));
  assign mem_ready = !RST && mem_valid && !(ex_valid && (last_grant_q == GrantMem));
  assign ex_fire   = ex_valid && ex_ready;
  assign mem_fire  = mem_valid && mem_ready;
  assign wr_en     = ex_fire || mem_fire;

  // Load formatting from the raw aligned word.
  always_comb begin
    ld_byte = mem_data[7:0];
    unique case (mem_byte_off)
      2'd0: ld_byte = mem_data[7:0];
      2'd1: ld_byte = mem_data[15:8];
      2'd2: ld_byte = mem_data[23:16];
      2'd3: ld_byte = mem_data[31:24];
    endcase
    ld_half = mem_byte_off[1] ? mem_data[31:16] : mem_data[15:0];

    ld_data = mem_data;
    case (mem_funct3)
      LB:      ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      LBU:     ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      LH:      ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      LHU:     ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = mem_data;
    endcase
  end

  assign wr_rd   = mem_fire ? mem_rd : ex_rd;
  assign wr_data = mem_fire ? ld_data : ex_data;

  always_comb begin
    last_grant_d = last_grant_q;
    pending_d    = pending_q;
    instret_d    = instret_q;
    if (conflict) last_grant_d = mem_fire ? GrantMem : GrantExec;
    if (wr_en) begin
      pending_d[wr_rd] = 1'b0;
      instret_d        = instret_q + 64'd1;
    end
    // Issue is applied after the clear so a same-cycle issue to the same rd stays pending.
    if (issue_valid && (issue_rd != 5'd0)) pending_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_grant_q <= GrantExec;
      pending_q    <= '0;
      instret_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
      instret_q    <= instret_d;
    end
  end

  rv_regfile #(
    .XLEN(XLEN),
    .NREG(NREG)
  ) u_regfile (
    .clk_i   (CLK),
    .rst_i   (RST),
    .we_i    (wr_en),
    .waddr_i (wr_rd),
    .wdata_i (wr_data),
    .raddr1_i(rs1_addr),
    .rdata1_o(rf_rdata1),
    .raddr2_i(rs2_addr),
    .rdata2_o(rf_rdata2)
  );

  assign instret = instret_q;

`ifdef WB_BYPASS_EN
  logic byp1, byp2;
  assign byp1        = wr_en && (wr_rd != 5'd0) && (wr_rd == rs1_addr);
  assign byp2        = wr_en && (wr_rd != 5'd0) && (wr_rd == rs2_addr);
  assign rs1_data    = byp1 ? wr_data : rf_rdata1;
  assign rs2_data    = byp2 ? wr_data : rf_rdata2;
  assign rs1_pending = (rs1_addr != 5'd0) && pending_q[rs1_addr] && !byp1;
  assign rs2_pending = (rs2_addr != 5'd0) && pending_q[rs2_addr] && !byp2;
`else
  assign rs1_data    = rf_rdata1;
  assign rs2_data    = rf_rdata2;
  assign rs1_pending = (rs1_addr != 5'd0) && pending_q[rs1_addr];
  assign rs2_pending = (rs2_addr != 5'd0) && pending_q[rs2_addr];
`endif

endmodule
